// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative 16-bit shift controller for the execute stage.
// Accepts one LSL/LSR/ASR/ROR request per start pulse and shifts at most STEP
// bit positions per clock, then pulses done_o with a held result and carry.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN enables ROR (op 2'b11). When the
// macro is undefined, op 2'b11 completes immediately with err_o=1 and no
// rotate logic is built.
module shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [15:0]      shift_amount_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o,
    output logic             err_o
);

    // Count registers must hold the full range 0..WIDTH.
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] W_C    = CW'(WIDTH);
    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] w_q;
    logic [CW-1:0]    rem_q;
    logic [1:0]       op_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             err_q;

    logic [CW-1:0]    n_eff;
    logic             req_err;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] sel;
    logic             step_carry;

    // Effective shift count and unsupported-op detection for the incoming request.
    always_comb begin
        n_eff   = (shift_amount_i >= 16'(WIDTH)) ? W_C : CW'(shift_amount_i);
        req_err = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (op_i == OP_ROR) begin
            n_eff = CW'(shift_amount_i % 16'(WIDTH));
        end
`else
        req_err = (op_i == OP_ROR);
`endif
    end

    // One iteration: shift the working value by k = min(rem, STEP).
    always_comb begin
        k          = (rem_q > STEP_C) ? STEP_C : rem_q;
        step_w     = w_q;
        sel        = '0;
        step_carry = 1'b0;
        case (op_q)
            OP_LSL: begin
                step_w = w_q << k;
                sel    = w_q >> (W_C - k);
            end
            OP_LSR: begin
                step_w = w_q >> k;
                sel    = w_q >> (k - ONE_C);
            end
            OP_ASR: begin
                step_w = WIDTH'($signed(w_q) >>> k);
                sel    = w_q >> (k - ONE_C);
            end
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR: begin
                // ROR counts are reduced mod WIDTH, so k < WIDTH here.
                step_w = (w_q >> k) | (w_q << (W_C - k));
                sel    = w_q >> (k - ONE_C);
            end
`endif
            default: begin
                step_w = w_q;
                sel    = '0;
            end
        endcase
        step_carry = sel[0];
    end

    // Sequencer FSM with registered outputs; result/carry/err move only on entry to DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            w_q         <= '0;
            rem_q       <= '0;
            op_q        <= OP_LSL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        w_q    <= data_in_i;
                        rem_q  <= n_eff;
                        op_q   <= op_i;
                        busy_q <= 1'b1;
                        if (req_err || (n_eff == '0)) begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            result_q    <= data_in_i;
                            carry_out_q <= 1'b0;
                            err_q       <= req_err;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    w_q   <= step_w;
                    rem_q <= rem_q - k;
                    if (rem_q == k) begin
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                        result_q    <= step_w;
                        carry_out_q <= step_carry;
                        err_q       <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign carry_out_o = carry_out_q;
    assign err_o       = err_q;

endmodule
